alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single 8-bit ALU between NREQ requesters, e.g. the main datapath and the branch/address unit.
- Arbitrates round-robin and drives the ALU inputs from a registered operation.
- Captures the ALU result and flags, then returns them over a valid/ready response channel.
- Holds a separate carry/zero flag context per requester, so add-with-carry and subtract-with-carry chains from one requester are never corrupted by another requester's operations.

Parameters:
- NREQ, 2, number of requesters (2..4)
- W, 8, ALU data width; must match the ALU instance

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- req_valid  in  NREQ  request present, one bit per requester
- req_ready  out  NREQ  one-cycle accept pulse, one-hot
- req_a  in  NREQ*W  operand A; slice i belongs to requester i
- req_b  in  NREQ*W  operand B / shift amount
- req_is_shift  in  NREQ  1 = shift operation
- req_scode  in  NREQ*2  shift code
- req_acode  in  NREQ*3  arithmetic/logic code
- resp_valid  out  NREQ  response present, one-hot
- resp_ready  in  NREQ  response consumed
- resp_r  out  W  result; valid while any resp_valid is high
- resp_zero  out  1  zero flag of this operation
- resp_carry  out  1  updated carry flag of the requester
- resp_err  out  1  illegal operation (acode 111, not shift)
- alu_a, alu_b  out  W  to ALU A, B
- alu_carry_in  out  1  to ALU carry_in
- alu_is_shift  out  1  to ALU is_shift
- alu_scode  out  2  to ALU scode
- alu_acode  out  3  to ALU acode
- alu_r  in  W  from ALU R
- alu_zero  in  1  from ALU zero
- alu_carry_out  in  1  from ALU carry_out

Behaviour:
- Reset: one clock, synchronous, active-low (rst_n sampled at clk rising edge).
  - All outputs 0; FSM to IDLE.
  - Per-requester C and Z flags cleared.
  - RR pointer set so requester 0 has highest priority.
- State IDLE:
  - If any req_valid is set, grant the first requester at or after (last_grant+1) mod NREQ.
  - Pulse req_ready[g] for that cycle.
  - Latch g, the operands and the codes into the op register.
  - Go to EXEC.
  - If no req_valid is set, stay in IDLE.
- State EXEC, one cycle:
  - alu_* outputs are driven from the op register.
  - alu_carry_in = C[g].
  - At the clock edge, capture alu_r, alu_zero and alu_carry_out; go to RESP.
- State RESP:
  - resp_valid[g]=1; resp_* are stable from registers.
  - Stay in RESP until resp_ready[g]=1, then return to IDLE and set last_grant=g.
  - No new grant is made while in RESP.
- Latency and throughput:
  - Accept at edge T, resp_valid high from T+2.
  - Peak throughput is one operation per 3 cycles when resp_ready is held high.
- alu_* outputs outside EXEC: all 0.
- Requester rule: request fields must stay stable while req_valid is high, until req_ready. The arbiter samples them only in the grant cycle.
- Flag update on leaving EXEC, for requester g only:
  - acode 000..011, not shift: C[g]<=alu_carry_out, Z[g]<=alu_zero.
  - acode 100..110, not shift: Z[g] updated, C[g] unchanged.
  - Shift with B!=0: C[g]<=alu_carry_out, Z[g] updated.
  - Shift with B==0: C[g] unchanged, Z[g] updated.
  - acode 111, not shift: resp_err=1, resp_r=0, C[g] and Z[g] unchanged; the ALU output is ignored.
- resp_carry reports C[g] after the update; resp_zero reports the operation's zero.
- Requesters not granted keep their flags untouched.
- A requester may hold req_valid through its own RESP. It is a grant candidate again in the next IDLE, subject to RR.
- Reset mid-operation (EXEC or RESP): the operation is abandoned, no response is issued, and flags are cleared.

Decomposition:
- Shared package alu_pkg:
  - acode constants ADD=000, ADC=001, SUB=010, SBC=011, AND=100, OR=101, XOR=110.
  - scode constants SHL, ASR, ROL, ROR.
  - FSM state encoding IDLE/EXEC/RESP.
- One sub-module, rr_arbiter: NREQ-bit request vector plus last_grant in, one-hot grant plus index out. Purely combinational, reusable by the bus controller.

Test Plan:
- req0 ADD A=0x03 B=0x04, resp_ready=1 -> req_ready[0] at T; alu_acode=000 with alu_a=3, alu_b=4 during T+1; resp_valid[0] at T+2 with resp_r=0x07, zero=0, err=0.
- req0 and req1 valid together, continuously, for 4 operations -> grant order 0,1,0,1; never two consecutive grants to one requester.
- Carry context:
  - req0 ADD 0x80+0x80 -> resp_r=0x00, zero=1, carry=1.
  - req1 ADC 0x01+0x01 -> alu_carry_in=0, resp_r=0x02.
  - req0 ADC 0x01+0x01 -> alu_carry_in=1, resp_r=0x03.
- req0 AND 0xF0&0x0F with C[0]=1 -> resp_r=0x00, zero=1, carry still 1.
- req0 shift with B=0 -> resp_r=A, C[0] unchanged.
- resp_ready[0] low for 5 cycles -> resp_valid[0] and resp_r held constant; a pending req1 is not granted until the handshake completes.
- rst_n low during EXEC -> no resp_valid, all outputs 0 next cycle; the next grant goes to req0.
- req1 acode 111 -> resp_err=1, resp_r=0, C[1] and Z[1] unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU encodings and arbiter FSM states, used by the ALU arbiter
// and anything else that issues operations to the 8-bit ALU.
package alu_pkg;

    localparam logic [2:0] AC_ADD = 3'b000;
    localparam logic [2:0] AC_ADC = 3'b001;
    localparam logic [2:0] AC_SUB = 3'b010;
    localparam logic [2:0] AC_SBC = 3'b011;
    localparam logic [2:0] AC_AND = 3'b100;
    localparam logic [2:0] AC_OR  = 3'b101;
    localparam logic [2:0] AC_XOR = 3'b110;
    localparam logic [2:0] AC_ILL = 3'b111;

    localparam logic [1:0] SC_SHL = 2'b00;
    localparam logic [1:0] SC_ASR = 2'b01;
    localparam logic [1:0] SC_ROL = 2'b10;
    localparam logic [1:0] SC_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    function automatic logic op_illegal(input logic is_shift, input logic [2:0] acode);
        return !is_shift && (acode == AC_ILL);
    endfunction

    // Arithmetic ops and real shifts produce a carry; logic ops and zero-distance shifts do not.
    function automatic logic op_writes_carry(input logic is_shift, input logic [2:0] acode,
                                             input logic b_nonzero);
        return is_shift ? b_nonzero : (acode[2] == 1'b0);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// (last_i + 1) mod NREQ. Shared with the bus controller.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDXW = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDXW-1:0] gnt_idx_o,
    output logic            any_o
);

    logic [IDXW-1:0] cand;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDXW'((32'(last_i) + k) % NREQ);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one 8-bit ALU between NREQ requesters: round-robin grant, one EXEC
// cycle on the ALU, registered response, and a private C/Z context per requester.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_is_shift,
    input  logic [NREQ*2-1:0] req_scode,
    input  logic [NREQ*3-1:0] req_acode,
    output logic [NREQ-1:0]   resp_valid,
    input  logic [NREQ-1:0]   resp_ready,
    output logic [W-1:0]      resp_r,
    output logic              resp_zero,
    output logic              resp_carry,
    output logic              resp_err,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    output logic              alu_carry_in,
    output logic              alu_is_shift,
    output logic [1:0]        alu_scode,
    output logic [2:0]        alu_acode,
    input  logic [W-1:0]      alu_r,
    input  logic              alu_zero,
    input  logic              alu_carry_out
);

    localparam int IDXW = $clog2(NREQ);

    state_t          state_q;
    logic [IDXW-1:0] gnt_q;
    logic [IDXW-1:0] last_q;
    logic [NREQ-1:0] c_q;
    logic [NREQ-1:0] z_q;

    logic [W-1:0]    alu_a_q;
    logic [W-1:0]    alu_b_q;
    logic            alu_cin_q;
    logic            alu_shift_q;
    logic [1:0]      alu_scode_q;
    logic [2:0]      alu_acode_q;

    logic [NREQ-1:0] resp_valid_q;
    logic [W-1:0]    resp_r_q;
    logic            resp_zero_q;
    logic            resp_carry_q;
    logic            resp_err_q;

    logic [NREQ-1:0] arb_gnt;
    logic [IDXW-1:0] arb_idx;
    logic            arb_any;

    logic            err_d;
    logic            carry_d;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr (
        .req_i     (req_valid),
        .last_i    (last_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx),
        .any_o     (arb_any)
    );

    // Grant is only offered from IDLE, and never while reset is asserted.
    assign req_ready = (rst_n && state_q == ST_IDLE) ? arb_gnt : '0;

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_carry_in = alu_cin_q;
    assign alu_is_shift = alu_shift_q;
    assign alu_scode    = alu_scode_q;
    assign alu_acode    = alu_acode_q;

    assign resp_valid = resp_valid_q;
    assign resp_r     = resp_r_q;
    assign resp_zero  = resp_zero_q;
    assign resp_carry = resp_carry_q;
    assign resp_err   = resp_err_q;

    always_comb begin
        err_d   = op_illegal(alu_shift_q, alu_acode_q);
        carry_d = c_q[gnt_q];
        if (!err_d && op_writes_carry(alu_shift_q, alu_acode_q, |alu_b_q)) begin
            carry_d = alu_carry_out;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            last_q       <= IDXW'(NREQ - 1);
            c_q          <= '0;
            z_q          <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_cin_q    <= 1'b0;
            alu_shift_q  <= 1'b0;
            alu_scode_q  <= '0;
            alu_acode_q  <= '0;
            resp_valid_q <= '0;
            resp_r_q     <= '0;
            resp_zero_q  <= 1'b0;
            resp_carry_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        gnt_q       <= arb_idx;
                        alu_a_q     <= req_a[arb_idx*W +: W];
                        alu_b_q     <= req_b[arb_idx*W +: W];
                        alu_shift_q <= req_is_shift[arb_idx];
                        alu_scode_q <= req_scode[arb_idx*2 +: 2];
                        alu_acode_q <= req_acode[arb_idx*3 +: 3];
                        alu_cin_q   <= c_q[arb_idx];
                        state_q     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (!err_d) begin
                        c_q[gnt_q] <= carry_d;
                        z_q[gnt_q] <= alu_zero;
                    end
                    resp_valid_q <= NREQ'(1) << gnt_q;
                    resp_r_q     <= err_d ? '0 : alu_r;
                    // An illegal op has no zero of its own; report the held context instead.
                    resp_zero_q  <= err_d ? z_q[gnt_q] : alu_zero;
                    resp_carry_q <= carry_d;
                    resp_err_q   <= err_d;
                    alu_a_q      <= '0;
                    alu_b_q      <= '0;
                    alu_cin_q    <= 1'b0;
                    alu_shift_q  <= 1'b0;
                    alu_scode_q  <= '0;
                    alu_acode_q  <= '0;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready[gnt_q]) begin
                        resp_valid_q <= '0;
                        resp_r_q     <= '0;
                        resp_zero_q  <= 1'b0;
                        resp_carry_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        last_q       <= gnt_q;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural 8-bit ALU attached.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int NREQ = 2;
    localparam int W    = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_is_shift;
    logic [NREQ*2-1:0] req_scode;
    logic [NREQ*3-1:0] req_acode;
    logic [NREQ-1:0]   resp_valid;
    logic [NREQ-1:0]   resp_ready;
    logic [W-1:0]      resp_r;
    logic              resp_zero;
    logic              resp_carry;
    logic              resp_err;
    logic [W-1:0]      alu_a;
    logic [W-1:0]      alu_b;
    logic              alu_carry_in;
    logic              alu_is_shift;
    logic [1:0]        alu_scode;
    logic [2:0]        alu_acode;
    logic [W-1:0]      alu_r;
    logic              alu_zero;
    logic              alu_carry_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_is_shift  (req_is_shift),
        .req_scode     (req_scode),
        .req_acode     (req_acode),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_r        (resp_r),
        .resp_zero     (resp_zero),
        .resp_carry    (resp_carry),
        .resp_err      (resp_err),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_carry_in  (alu_carry_in),
        .alu_is_shift  (alu_is_shift),
        .alu_scode     (alu_scode),
        .alu_acode     (alu_acode),
        .alu_r         (alu_r),
        .alu_zero      (alu_zero),
        .alu_carry_out (alu_carry_out)
    );

    // Behavioural ALU. Subtract carry is a borrow. The illegal code returns
    // deliberately bogus values so that forwarding them is visible.
    logic [8:0] t;
    always_comb begin
        t             = '0;
        alu_r         = '0;
        alu_carry_out = 1'b0;
        alu_zero      = 1'b0;
        if (alu_is_shift) begin
            case (alu_scode)
                SC_SHL: begin
                    t             = {1'b0, alu_a} << alu_b;
                    alu_r         = t[7:0];
                    alu_carry_out = t[8];
                end
                SC_ASR:  alu_r = $unsigned($signed(alu_a) >>> alu_b[2:0]);
                SC_ROL:  alu_r = (alu_a << alu_b[2:0]) | (alu_a >> (4'd8 - {1'b0, alu_b[2:0]}));
                default: alu_r = (alu_a >> alu_b[2:0]) | (alu_a << (4'd8 - {1'b0, alu_b[2:0]}));
            endcase
            alu_zero = (alu_r == '0);
        end else begin
            case (alu_acode)
                AC_ADD:  t = {1'b0, alu_a} + {1'b0, alu_b};
                AC_ADC:  t = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_carry_in};
                AC_SUB:  t = {1'b0, alu_a} - {1'b0, alu_b};
                AC_SBC:  t = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_carry_in};
                AC_AND:  t = {1'b0, alu_a & alu_b};
                AC_OR:   t = {1'b0, alu_a | alu_b};
                AC_XOR:  t = {1'b0, alu_a ^ alu_b};
                default: t = 9'h1FF;
            endcase
            alu_r         = t[7:0];
            alu_carry_out = t[8];
            alu_zero      = (alu_acode == AC_ILL) ? 1'b1 : (t[7:0] == 8'h00);
        end
    end

    logic [63:0] outs;
    assign outs = {26'd0, req_ready, resp_valid, resp_r, resp_zero, resp_carry, resp_err,
                   alu_a, alu_b, alu_carry_in, alu_is_shift, alu_scode, alu_acode};

    typedef struct {
        int         rq;
        logic       sh;
        logic [1:0] sc;
        logic [2:0] ac;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] r;
        logic       z;
        logic       c;
        logic       e;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_req(input vec_t v);
        req_a[v.rq*W +: W]      = v.a;
        req_b[v.rq*W +: W]      = v.b;
        req_is_shift[v.rq]      = v.sh;
        req_scode[v.rq*2 +: 2]  = v.sc;
        req_acode[v.rq*3 +: 3]  = v.ac;
    endtask

    task automatic run_op(input vec_t v, input string tag);
        bit         got;
        logic [1:0] oh;
        got = 1'b0;
        oh  = 2'(1 << v.rq);
        @(negedge clk);
        drive_req(v);
        req_valid  = oh;
        resp_ready = 2'b11;
        for (int k = 0; k < 8 && !got; k++) begin
            #1;
            if (req_ready != '0) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s grant: got no req_ready within 8 cycles, required %0h", tag, oh);
            req_valid = '0;
            return;
        end
        chk({tag, " req_ready"}, req_ready, oh);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk({tag, " alu_a"}, alu_a, v.a);
        chk({tag, " alu_b"}, alu_b, v.b);
        chk({tag, " alu_is_shift"}, alu_is_shift, v.sh);
        chk({tag, " alu_scode"}, alu_scode, v.sc);
        chk({tag, " alu_acode"}, alu_acode, v.ac);
        chk({tag, " alu_carry_in"}, alu_carry_in, v.cin);
        chk({tag, " resp_valid in EXEC"}, resp_valid, 2'b00);
        @(negedge clk);
        #1;
        chk({tag, " resp_valid"}, resp_valid, oh);
        chk({tag, " resp_r"}, resp_r, v.r);
        chk({tag, " resp_carry"}, resp_carry, v.c);
        chk({tag, " resp_err"}, resp_err, v.e);
        if (!v.e) chk({tag, " resp_zero"}, resp_zero, v.z);
        chk({tag, " alu idle in RESP"}, {alu_a, alu_b, alu_acode}, 19'd0);
    endtask

    vec_t       vt[12];
    vec_t       s0, s1;
    logic [1:0] gseq[4];
    logic [1:0] gexp[4];
    int         ng;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          rq sh    sc      ac      a      b      cin   r      z     c     e
        vt[0]  = '{0, 1'b0, SC_SHL, AC_ADD, 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{0, 1'b0, SC_SHL, AC_ADD, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        vt[2]  = '{1, 1'b0, SC_SHL, AC_ADC, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{0, 1'b0, SC_SHL, AC_ADC, 8'h01, 8'h01, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{0, 1'b0, SC_SHL, AC_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        vt[5]  = '{0, 1'b0, SC_SHL, AC_AND, 8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
        vt[6]  = '{0, 1'b1, SC_SHL, AC_ADD, 8'h5A, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0};
        vt[7]  = '{1, 1'b0, SC_SHL, AC_SUB, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b1, 1'b0};
        vt[8]  = '{1, 1'b0, SC_SHL, AC_ILL, 8'h12, 8'h34, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
        vt[9]  = '{1, 1'b0, SC_SHL, AC_SBC, 8'h09, 8'h03, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0};
        vt[10] = '{0, 1'b1, SC_SHL, AC_ADD, 8'h41, 8'h01, 1'b1, 8'h82, 1'b0, 1'b0, 1'b0};
        vt[11] = '{1, 1'b0, SC_SHL, AC_AND, 8'hFF, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};

        rst_n        = 1'b0;
        req_valid    = 2'b11;
        req_a        = '0;
        req_b        = '0;
        req_is_shift = '0;
        req_scode    = '0;
        req_acode    = '0;
        resp_ready   = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset outputs", outs, 64'd0);
        req_valid = '0;
        rst_n     = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vt[i], $sformatf("vec%0d", i));
        end

        // resp_ready[0] held low: response must hold and req1 must wait.
        s0 = '{0, 1'b0, SC_SHL, AC_ADD, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0};
        s1 = '{1, 1'b0, SC_SHL, AC_XOR, 8'h0F, 8'h0F, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        @(negedge clk);
        drive_req(s0);
        drive_req(s1);
        req_valid  = 2'b11;
        resp_ready = 2'b10;
        #1;
        chk("stall grant r0", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b10;
        #1;
        chk("stall exec alu_a", alu_a, 8'h10);
        chk("stall exec no grant", req_ready, 2'b00);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("stall%0d resp_valid", k), resp_valid, 2'b01);
            chk($sformatf("stall%0d resp_r", k), resp_r, 8'h30);
            chk($sformatf("stall%0d no grant", k), req_ready, 2'b00);
        end
        resp_ready = 2'b11;
        @(negedge clk);
        #1;
        chk("after stall grant r1", req_ready, 2'b10);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("r1 exec acode", alu_acode, AC_XOR);
        chk("r1 exec cin", alu_carry_in, 1'b0);
        @(negedge clk);
        #1;
        chk("r1 resp_valid", resp_valid, 2'b10);
        chk("r1 resp_r", resp_r, 8'h00);
        chk("r1 resp_zero", resp_zero, 1'b1);
        chk("r1 resp_carry", resp_carry, 1'b0);

        // Both requesters continuously valid: grants must alternate.
        s0 = '{0, 1'b0, SC_SHL, AC_ADD, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
        s1 = '{1, 1'b0, SC_SHL, AC_ADD, 8'h02, 8'h02, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0};
        gexp[0] = 2'b01; gexp[1] = 2'b10; gexp[2] = 2'b01; gexp[3] = 2'b10;
        for (int i = 0; i < 4; i++) gseq[i] = 2'b00;
        ng = 0;
        @(negedge clk);
        drive_req(s0);
        drive_req(s1);
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        for (int k = 0; k < 40 && ng < 4; k++) begin
            #1;
            if (req_ready != '0) begin
                gseq[ng] = req_ready;
                ng++;
            end
            @(negedge clk);
        end
        req_valid = '0;
        chk("rr grant count", ng, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr grant%0d", i), gseq[i], gexp[i]);
        end

        // Set C[0]=1 and last_grant=0, then abandon a req1 op with reset in EXEC.
        s0 = '{0, 1'b0, SC_SHL, AC_ADD, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        run_op(s0, "pre-reset");
        s1 = '{1, 1'b0, SC_SHL, AC_ADD, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
        @(negedge clk);
        drive_req(s1);
        req_valid  = 2'b10;
        resp_ready = 2'b11;
        #1;
        chk("pre-reset grant r1", req_ready, 2'b10);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("pre-reset exec alu_a", alu_a, 8'h01);
        rst_n = 1'b0;
        s0 = '{0, 1'b0, SC_SHL, AC_ADC, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
        @(negedge clk);
        drive_req(s0);
        req_valid = 2'b11;
        #1;
        chk("mid-op reset outputs", outs, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("post-reset grant r0", req_ready, 2'b01);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("post-reset cin cleared", alu_carry_in, 1'b0);
        chk("post-reset acode", alu_acode, AC_ADC);
        @(negedge clk);
        #1;
        chk("post-reset resp_valid", resp_valid, 2'b01);
        chk("post-reset resp_r", resp_r, 8'h02);
        chk("post-reset resp_carry", resp_carry, 1'b0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
